// File: rtl/entropy_dc_slice_sequencer.sv
// DC coefficient slice sequencer: issues DC buffer reads, feeds the entropy encoder and
// queues codewords for downstream. Define DC_SLICE_BIT_COUNT_EN to implement slice_bits.
module entropy_dc_slice_sequencer #(
  parameter int MAX_BLOCKS  = 32,
  parameter int ENC_LATENCY = 4,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  num_blocks,
  output logic [4:0]  dc_rd_addr,
  input  logic [19:0] dc_rd_data,
  output logic [19:0] enc_dc_coeff,
  output logic        enc_valid,
  output logic        enc_first,
  input  logic [23:0] enc_code,
  input  logic [5:0]  enc_len,
  input  logic        enc_code_valid,
  output logic [23:0] out_code,
  output logic [5:0]  out_len,
  output logic        out_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic [15:0] slice_bits
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [5:0] MAX_N = 6'(MAX_BLOCKS);

  if (FIFO_DEPTH < ENC_LATENCY + 2 || (1 << PW) != FIFO_DEPTH) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least ENC_LATENCY+2");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t state, next_state;

  logic [5:0]    nblk_q;
  logic [5:0]    nblk_clamped;
  logic [5:0]    issue_cnt;
  logic [5:0]    ret_cnt;
  logic          rd_valid_q;
  logic          rd_first_q;
  logic [CW-1:0] inflight;
  logic [CW-1:0] fifo_count;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW:0]   credit_sum;
  logic          issue_fire;
  logic          last_issue;
  logic          accept;
  logic          pop;
  logic          head_last;
  logic          start_ok;

  logic [23:0] code_mem [FIFO_DEPTH];
  logic [5:0]  len_mem  [FIFO_DEPTH];
  logic        last_mem [FIFO_DEPTH];

  assign nblk_clamped = (num_blocks > MAX_N) ? MAX_N : num_blocks;
  assign start_ok     = (state == IDLE) && start;
  assign last_issue   = (issue_cnt == nblk_q - 6'd1);

  // Reads already issued but not yet presented to the encoder still hold a FIFO slot.
  assign credit_sum = (CW+1)'(inflight) + (CW+1)'(fifo_count) + (CW+1)'(rd_valid_q);

  assign accept    = enc_code_valid && busy && (inflight != '0);
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;
  assign head_last = last_mem[rd_ptr];

  assign dc_rd_addr   = issue_cnt[4:0];
  assign enc_valid    = rd_valid_q;
  assign enc_first    = rd_first_q;
  assign enc_dc_coeff = rd_valid_q ? dc_rd_data : '0;
  assign out_code     = out_valid ? code_mem[rd_ptr] : '0;
  assign out_len      = out_valid ? len_mem[rd_ptr] : '0;
  assign out_last     = out_valid && head_last;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (start) next_state = (nblk_clamped == 6'd0) ? DONE : ISSUE;
      ISSUE: if (issue_fire && last_issue) next_state = DRAIN;
      DRAIN: if (pop && head_last) next_state = DONE;
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state == ISSUE) || (state == DRAIN);
    done       = (state == DONE);
    issue_fire = (state == ISSUE) && (credit_sum < (CW+1)'(FIFO_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      nblk_q     <= '0;
      issue_cnt  <= '0;
      ret_cnt    <= '0;
      rd_valid_q <= 1'b0;
      rd_first_q <= 1'b0;
      inflight   <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      rd_valid_q <= issue_fire;
      rd_first_q <= issue_fire && (issue_cnt == 6'd0);

      if (start_ok) begin
        nblk_q    <= nblk_clamped;
        issue_cnt <= '0;
        ret_cnt   <= '0;
      end else begin
        if (issue_fire)          issue_cnt <= issue_cnt + 6'd1;
        else if (state == DONE)  issue_cnt <= '0;
        if (accept)              ret_cnt <= ret_cnt + 6'd1;
      end

      unique case ({rd_valid_q, accept})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase

      if (accept) wr_ptr <= wr_ptr + PW'(1);
      if (pop)    rd_ptr <= rd_ptr + PW'(1);

      unique case ({accept, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      code_mem[wr_ptr] <= enc_code;
      len_mem[wr_ptr]  <= enc_len;
      last_mem[wr_ptr] <= (ret_cnt == nblk_q - 6'd1);
    end
  end

`ifdef DC_SLICE_BIT_COUNT_EN
  logic [15:0] bits_q;
  logic [16:0] bits_sum;

  assign bits_sum   = {1'b0, bits_q} + 17'(out_len);
  assign slice_bits = bits_q;

  always_ff @(posedge clk) begin
    if (reset)         bits_q <= '0;
    else if (start_ok) bits_q <= '0;
    else if (pop)      bits_q <= bits_sum[16] ? '1 : bits_sum[15:0];
  end
`else
  assign slice_bits = '0;
`endif

endmodule

// File: tb/tb_entropy_dc_slice_sequencer.sv
// Directed bench for entropy_dc_slice_sequencer with a delay-line encoder model and DC buffer model.
module tb_entropy_dc_slice_sequencer;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        reset, start, out_ready;
  logic [5:0]  num_blocks;
  logic [4:0]  dc_rd_addr;
  logic [19:0] dc_rd_data, enc_dc_coeff;
  logic        enc_valid, enc_first, enc_code_valid;
  logic [23:0] enc_code, out_code;
  logic [5:0]  enc_len, out_len;
  logic        out_last, out_valid, busy, done;
  logic [15:0] slice_bits;

  entropy_dc_slice_sequencer #(.MAX_BLOCKS(32), .ENC_LATENCY(LAT), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .num_blocks(num_blocks),
    .dc_rd_addr(dc_rd_addr), .dc_rd_data(dc_rd_data),
    .enc_dc_coeff(enc_dc_coeff), .enc_valid(enc_valid), .enc_first(enc_first),
    .enc_code(enc_code), .enc_len(enc_len), .enc_code_valid(enc_code_valid),
    .out_code(out_code), .out_len(out_len), .out_last(out_last), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done), .slice_bits(slice_bits)
  );

  always #5 clk = ~clk;

  // DC buffer: entry a holds 0x12300+a, one-cycle read latency.
  always @(posedge clk) dc_rd_data <= 20'h12300 + 20'(dc_rd_addr);

  // Encoder: fixed LAT-cycle delay line, codeword tags the coefficient.
  logic [LAT-1:0] vpipe = '0;
  logic [19:0]    cpipe [LAT];
  always @(posedge clk) begin
    vpipe <= {vpipe[LAT-2:0], enc_valid};
    cpipe[0] <= enc_dc_coeff;
    for (int i = 1; i < LAT; i++) cpipe[i] <= cpipe[i-1];
  end
  assign enc_code_valid = vpipe[LAT-1];
  assign enc_code       = {4'h5, cpipe[LAT-1]};
  assign enc_len        = 6'd6;

  typedef struct {
    int nb;
    int hold;
    int restart;
    int exp_n;
    int exp_stall;
    int exp_busy;
  } vec_t;

  vec_t vecs[8];
  int nvec = 0, nerr = 0;
  int enc_idx, pop_idx, ret_idx, done_cnt, busy_cnt, cur_n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    check("enc_first", 32'(enc_first), 32'(enc_valid && enc_idx == 0));
    if (enc_valid) begin
      check("enc_dc_coeff", 32'(enc_dc_coeff), 32'(20'h12300 + 20'(enc_idx)));
      enc_idx++;
    end
    if (enc_code_valid) ret_idx++;
    if (out_valid && out_ready) begin
      check("out_code", 32'(out_code), 32'({4'h5, 20'h12300 + 20'(pop_idx)}));
      check("out_len", 32'(out_len), 32'd6);
      check("out_last", 32'(out_last), 32'(pop_idx == cur_n - 1));
      pop_idx++;
    end
    if (done) done_cnt++;
    if (busy) busy_cnt++;
  endtask

  task automatic tick();
    #1;
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    enc_idx = 0; pop_idx = 0; ret_idx = 0; done_cnt = 0; busy_cnt = 0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_addr"}, 32'(dc_rd_addr), 32'd0);
    check({tag, "_enc_valid"}, 32'(enc_valid), 32'd0);
    check({tag, "_enc_first"}, 32'(enc_first), 32'd0);
    check({tag, "_coeff"}, 32'(enc_dc_coeff), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_code"}, 32'(out_code), 32'd0);
    check({tag, "_out_len"}, 32'(out_len), 32'd0);
    check({tag, "_out_last"}, 32'(out_last), 32'd0);
    check({tag, "_slice_bits"}, 32'(slice_bits), 32'd0);
  endtask

  task automatic run_slice(input vec_t v);
    int cyc;
    int post;
    int exp_bits;
`ifdef DC_SLICE_BIT_COUNT_EN
    exp_bits = v.exp_n * 6;
`else
    exp_bits = 0;
`endif
    clear_mon();
    cur_n = v.exp_n;
    num_blocks = 6'(v.nb);
    start = 1'b1;
    out_ready = (v.hold == 0);
    tick();
    start = 1'b0;
    num_blocks = '0;
    cyc = 1;
    post = -1;
    while (cyc < 3000 && post < 3) begin
      if (v.hold > 0 && cyc == v.hold) begin
        check("stall_reads", 32'(enc_idx), 32'(v.exp_stall));
        check("stall_returns", 32'(ret_idx), 32'(v.exp_stall));
        check("stall_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
      end
      if (v.restart > 0 && cyc == v.restart) begin
        start = 1'b1;
        num_blocks = 6'd20;
      end
      tick();
      start = 1'b0;
      num_blocks = '0;
      cyc++;
      if (post >= 0) post++;
      else if (done_cnt > 0) post = 0;
    end
    check("reads", 32'(enc_idx), 32'(v.exp_n));
    check("returns", 32'(ret_idx), 32'(v.exp_n));
    check("pops", 32'(pop_idx), 32'(v.exp_n));
    check("done_count", 32'(done_cnt), 32'd1);
    check("busy_seen", 32'(busy_cnt > 0), 32'(v.exp_busy));
    check("slice_bits", 32'(slice_bits), 32'(exp_bits));
    check("end_out_valid", 32'(out_valid), 32'd0);
    check("end_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    vecs[0] = '{4,  0,  0, 4,  0, 1};
    vecs[1] = '{32, 40, 0, 32, 8, 1};
    vecs[2] = '{40, 0,  0, 32, 0, 1};
    vecs[3] = '{4,  12, 8, 4,  4, 1};
    vecs[4] = '{0,  0,  0, 0,  0, 0};
    vecs[5] = '{1,  0,  0, 1,  0, 1};
    vecs[6] = '{63, 0,  0, 32, 0, 1};
    vecs[7] = '{9,  20, 0, 9,  8, 1};

    reset = 1'b1; start = 1'b0; num_blocks = '0; out_ready = 1'b0;
    clear_mon();
    cur_n = 0;
    repeat (3) tick();
    check_zero_outputs("reset");
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_slice(vecs[i]);

    // Zero blocks: done exactly one cycle after start, no busy.
    clear_mon();
    cur_n = 0;
    num_blocks = 6'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("zero_done", 32'(done), 32'd1);
    check("zero_busy", 32'(busy), 32'd0);
    tick();
    check("zero_done_drop", 32'(done), 32'd0);
    repeat (3) tick();
    check("zero_reads", 32'(enc_idx), 32'd0);

    // Abort: reset three cycles into a 16-block slice.
    clear_mon();
    cur_n = 16;
    num_blocks = 6'd16;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    num_blocks = '0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    check_zero_outputs("abort");
    reset = 1'b0;
    repeat (8) tick();
    check("abort_reads", 32'(enc_idx), 32'd2);
    check("abort_late_returns", 32'(ret_idx), 32'd2);
    check("abort_pops", 32'(pop_idx), 32'd0);
    check("abort_done", 32'(done_cnt), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);

    run_slice(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
